// File: rtl/airlock_controller_if.sv
// Operator-panel and chamber signals of the airlock controller.
// The controller attaches through the slave modport; the panel/chamber side uses master.
interface airlock_controller_if;
  logic outerReq;
  logic innerReq;
  logic doorBlocked;
  logic pressurized;
  logic evacuated;
  logic pressurizeCtrl;
  logic evacuateCtrl;
  logic outerDoorOpen;
  logic innerDoorOpen;
  logic busy;
  logic fault;

  modport master (
    output outerReq, innerReq, doorBlocked, pressurized, evacuated,
    input  pressurizeCtrl, evacuateCtrl, outerDoorOpen, innerDoorOpen, busy, fault
  );

  modport slave (
    input  outerReq, innerReq, doorBlocked, pressurized, evacuated,
    output pressurizeCtrl, evacuateCtrl, outerDoorOpen, innerDoorOpen, busy, fault
  );
endinterface

// File: rtl/airlock_controller.sv
// Airlock sequencer: closes doors, drives the chamber to the required state, then
// opens the requested door for a dwell. A watchdog latches a sticky fault.
module airlock_controller #(
  parameter int unsigned DOOR_CYCLES = 8,
  parameter int unsigned TIMEOUT     = 16
) (
  input logic                 clk,
  input logic                 rst,
  airlock_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    EVAC,
    PRESS,
    OPEN_OUTER,
    OPEN_INNER,
    FAULT
  } state_t;

  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [7:0] DOOR_LAST = 8'(DOOR_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 8'd1;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (bus.outerReq)
          state_nx = bus.evacuated ? OPEN_OUTER : EVAC;
        else if (bus.innerReq)
          state_nx = bus.pressurized ? OPEN_INNER : PRESS;
      end
      // Chamber status outranks the watchdog on the final allowed cycle.
      EVAC: begin
        if (bus.evacuated)
          state_nx = OPEN_OUTER;
        else if (cnt == TO_LAST)
          state_nx = FAULT;
      end
      PRESS: begin
        if (bus.pressurized)
          state_nx = OPEN_INNER;
        else if (cnt == TO_LAST)
          state_nx = FAULT;
      end
      OPEN_OUTER, OPEN_INNER: begin
        if (bus.doorBlocked)
          cnt_nx = '0;
        else if (cnt == DOOR_LAST)
          state_nx = IDLE;
      end
      FAULT: cnt_nx = '0;
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    if (state_nx != state)
      cnt_nx = '0;
  end

  // Outputs depend on the state register alone.
  always_comb begin
    bus.pressurizeCtrl = (state == PRESS);
    bus.evacuateCtrl   = (state == EVAC);
    bus.outerDoorOpen  = (state == OPEN_OUTER);
    bus.innerDoorOpen  = (state == OPEN_INNER);
    bus.busy           = (state != IDLE);
    bus.fault          = (state == FAULT);
  end

endmodule

// File: tb/tb_airlock_controller.sv
// Self-checking bench for airlock_controller: directed scenarios plus random traffic,
// compared every cycle against a countdown-based behavioural model.
module tb_airlock_controller;

  localparam int unsigned DOOR = 8;
  localparam int unsigned TMO  = 16;

  logic clk;
  logic rst;
  airlock_controller_if bus ();

  airlock_controller #(.DOOR_CYCLES(DOOR), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: ctrl 0 none/1 evacuate/2 pressurize, door 0 none/1 outer/2 inner.
  int m_ctrl, m_door, m_remain, m_elapsed;
  bit m_fault;

  logic [5:0] dut_vec;
  assign dut_vec = {bus.pressurizeCtrl, bus.evacuateCtrl, bus.outerDoorOpen,
                    bus.innerDoorOpen, bus.busy, bus.fault};

  function automatic logic [5:0] exp_vec();
    return {m_ctrl == 2, m_ctrl == 1, m_door == 1, m_door == 2,
            (m_fault || m_ctrl != 0 || m_door != 0), m_fault};
  endfunction

  function automatic void model_reset();
    m_ctrl = 0; m_door = 0; m_remain = 0; m_elapsed = 0; m_fault = 0;
  endfunction

  function automatic void model_step();
    bit st;
    if (!rst) begin
      model_reset();
    end else if (m_fault) begin
    end else if (m_door != 0) begin
      if (bus.doorBlocked) m_remain = DOOR;
      else begin
        m_remain--;
        if (m_remain == 0) m_door = 0;
      end
    end else if (m_ctrl != 0) begin
      st = (m_ctrl == 1) ? bus.evacuated : bus.pressurized;
      if (st) begin
        m_door = m_ctrl; m_remain = DOOR; m_ctrl = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == TMO) begin
          m_fault = 1; m_ctrl = 0;
        end
      end
    end else if (bus.outerReq) begin
      if (bus.evacuated) begin m_door = 1; m_remain = DOOR; end
      else begin m_ctrl = 1; m_elapsed = 0; end
    end else if (bus.innerReq) begin
      if (bus.pressurized) begin m_door = 2; m_remain = DOOR; end
      else begin m_ctrl = 2; m_elapsed = 0; end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.outerReq = 0; bus.innerReq = 0; bus.doorBlocked = 0;
    bus.pressurized = 0; bus.evacuated = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    bus.evacuated = 1;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if (dut_vec !== 6'b0) begin
      bad++; $display("FAIL reset_hold: got %b want %b", dut_vec, 6'b0);
    end
    rst = 1;
    step();
    total++;
    if (dut_vec !== exp_vec()) begin
      bad++; $display("FAIL reset_release: got %b want %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_outer_open();
    int opened = 0;
    bus.evacuated = 1;
    bus.outerReq  = 1;
    step();
    bus.outerReq = 0;
    for (int i = 0; i < 14; i++) begin
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL outer_open cyc %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (bus.outerDoorOpen) opened++;
      step();
    end
    total++;
    if (opened != DOOR) begin
      bad++; $display("FAIL outer_dwell: got %0d want %0d", opened, DOOR);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL outer_idle_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_press_cycle();
    int pc = 0, dc = 0, overlap = 0;
    bus.evacuated = 1; bus.pressurized = 0;
    bus.innerReq = 1;
    step();
    bus.innerReq = 0;
    bus.evacuated = 0;
    for (int i = 0; i < 24; i++) begin
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL press_cycle cyc %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (bus.pressurizeCtrl) pc++;
      if (bus.innerDoorOpen) dc++;
      if ((bus.innerDoorOpen || bus.outerDoorOpen) && (bus.pressurizeCtrl || bus.evacuateCtrl))
        overlap++;
      if (i == 6) bus.pressurized = 1;
      step();
    end
    total++;
    if (pc != 7) begin bad++; $display("FAIL press_ctrl_len: got %0d want 7", pc); end
    total++;
    if (dc != DOOR) begin bad++; $display("FAIL press_door_len: got %0d want %0d", dc, DOOR); end
    total++;
    if (overlap != 0) begin bad++; $display("FAIL door_ctrl_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_blocked();
    int dc = 0, ec = 0;
    bus.pressurized = 1; bus.evacuated = 0;
    bus.innerReq = 1;
    step();
    bus.innerReq = 0;
    for (int i = 0; i < 30; i++) begin
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL blocked cyc %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (bus.innerDoorOpen) dc++;
      if (bus.evacuateCtrl) ec++;
      bus.doorBlocked = (i >= 4 && i <= 9);
      bus.outerReq    = (i == 2);
      step();
    end
    bus.doorBlocked = 0; bus.outerReq = 0;
    total++;
    if (dc != 10 + DOOR) begin bad++; $display("FAIL blocked_dwell: got %0d want %0d", dc, 10 + DOOR); end
    total++;
    if (ec != 0) begin bad++; $display("FAIL ignored_req_evac: got %0d want 0", ec); end
  endtask

  task automatic test_timeout();
    int ec = 0;
    bus.pressurized = 1; bus.evacuated = 0;
    bus.outerReq = 1;
    step();
    bus.outerReq = 0;
    for (int i = 0; i < 40; i++) begin
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL timeout cyc %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (bus.evacuateCtrl) ec++;
      bus.innerReq = (i == 25);
      if (i == 30) bus.evacuated = 1;
      bus.outerReq = (i == 31);
      step();
    end
    bus.innerReq = 0; bus.outerReq = 0;
    total++;
    if (ec != TMO) begin bad++; $display("FAIL timeout_ctrl_len: got %0d want %0d", ec, TMO); end
    total++;
    if ({bus.fault, bus.busy, bus.outerDoorOpen} !== 3'b110) begin
      bad++; $display("FAIL fault_sticky: got %b want 110", {bus.fault, bus.busy, bus.outerDoorOpen});
    end
    do_reset();
  endtask

  task automatic test_both_req();
    int oc = 0, ic = 0;
    clear_inputs();
    bus.evacuated = 1; bus.pressurized = 1;
    bus.outerReq = 1; bus.innerReq = 1;
    step();
    bus.outerReq = 0; bus.innerReq = 0;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL both_req cyc %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (bus.outerDoorOpen) oc++;
      if (bus.innerDoorOpen) ic++;
      step();
    end
    total++;
    if (oc != DOOR || ic != 0) begin
      bad++; $display("FAIL both_req_winner: got outer=%0d inner=%0d want outer=%0d inner=0", oc, ic, DOOR);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    bus.innerReq = 1;
    step();
    bus.innerReq = 0;
    step();
    step();
    total++;
    if (bus.pressurizeCtrl !== 1'b1) begin
      bad++; $display("FAIL mid_reset_pre: got %b want 1", bus.pressurizeCtrl);
    end
    #3 rst = 0;
    #1;
    model_reset();
    total++;
    if (dut_vec !== 6'b0) begin
      bad++; $display("FAIL mid_reset_async: got %b want %b", dut_vec, 6'b0);
    end
    @(negedge clk);
    rst = 1;
    step();
    total++;
    if (dut_vec !== exp_vec() || bus.busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset_idle: got %b want %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_status_boundary();
    for (int late = 0; late < 2; late++) begin
      do_reset();
      clear_inputs();
      bus.innerReq = 1;
      step();
      bus.innerReq = 0;
      for (int k = 1; k <= int'(TMO) + late; k++) begin
        total++;
        if (dut_vec !== exp_vec()) begin
          bad++; $display("FAIL boundary%0d cyc %0d: got %b want %b", late, k, dut_vec, exp_vec());
        end
        if (k == int'(TMO) + late) bus.pressurized = 1;
        step();
      end
      total++;
      if ({bus.innerDoorOpen, bus.fault} !== ((late == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL boundary%0d_result: got door,fault=%b want %b", late,
                        {bus.innerDoorOpen, bus.fault}, (late == 0) ? 2'b10 : 2'b01);
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    clear_inputs();
    for (int i = 0; i < 600; i++) begin
      bus.outerReq    = ($urandom_range(0, 7) == 0);
      bus.innerReq    = ($urandom_range(0, 7) == 0);
      bus.doorBlocked = ($urandom_range(0, 5) == 0);
      bus.pressurized = ($urandom_range(0, 9) == 0);
      bus.evacuated   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) begin
        rst = 0;
        model_reset();
      end else begin
        rst = 1;
      end
      step();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL random cyc %0d: got %b want %b", i, dut_vec, exp_vec());
      end
    end
    rst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_outer_open();
    test_press_cycle();
    test_blocked();
    test_timeout();
    test_both_req();
    test_reset_mid();
    test_status_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/airlock_controller.md
# airlock_controller

Sequencing FSM that sits directly upstream of the airlock chamber block. It turns single-cycle door requests from the operator panel into a safe sequence: close both doors, drive the chamber's pressurize or evacuate control until the chamber reports the matching state, then open the requested door for a fixed dwell. It consumes the chamber's `pressurized`/`evacuated` status. A watchdog latches a fault if the chamber does not respond in time.

## Interface
- `DOOR_CYCLES`, default 8: door-open dwell in clock cycles; legal range 1..255.
- `TIMEOUT`, default 16: maximum cycles allowed for the chamber to report completion; legal range 2..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low. While `rst`=0 the block is held in reset.
- `outerReq`  in  1  single-cycle request to open the outer (vacuum-side) door.
- `innerReq`  in  1  single-cycle request to open the inner (habitat-side) door.
- `doorBlocked`  in  1  obstruction sensor; level.
- `pressurized`  in  1  chamber status.
- `evacuated`  in  1  chamber status.
- `pressurizeCtrl`  out  1  to chamber; level.
- `evacuateCtrl`  out  1  to chamber; level.
- `outerDoorOpen`  out  1  outer door actuator.
- `innerDoorOpen`  out  1  inner door actuator.
- `busy`  out  1  high in every state except IDLE.
- `fault`  out  1  watchdog fault; sticky.

## Operation
- States: IDLE, EVAC, PRESS, OPEN_OUTER, OPEN_INNER, FAULT. Reset state is IDLE.
- All outputs are decoded from the state register only. There is no combinational path from inputs to outputs.
- Output decode by state:
  - EVAC: `evacuateCtrl`=1.
  - PRESS: `pressurizeCtrl`=1.
  - OPEN_OUTER: `outerDoorOpen`=1.
  - OPEN_INNER: `innerDoorOpen`=1.
  - FAULT: `fault`=1.
  - `busy` = (state != IDLE).
  - All other outputs are 0.
- Reset values: every output is 0.
- An 8-bit counter `cnt` is cleared on every state transition.
- IDLE transitions:
  - `outerReq`=1 with `evacuated`=1 → OPEN_OUTER.
  - `outerReq`=1 with `evacuated`=0 → EVAC.
  - `innerReq`=1 with `pressurized`=1 → OPEN_INNER.
  - `innerReq`=1 with `pressurized`=0 → PRESS.
  - If both requests arrive in the same cycle, `outerReq` wins and `innerReq` is dropped.
- Requests arriving in any state other than IDLE are ignored, not queued.
- EVAC: `cnt` increments each cycle.
  - `evacuated`=1 → OPEN_OUTER.
  - Otherwise, if `cnt`==TIMEOUT-1 → FAULT.
  - The status check has priority over the timeout in the same cycle.
- PRESS: same as EVAC, with `pressurized` as the status and OPEN_INNER as the next state.
- OPEN_OUTER / OPEN_INNER:
  - `doorBlocked`=1 clears `cnt` to 0.
  - Otherwise `cnt` increments.
  - When `cnt`==DOOR_CYCLES-1 and `doorBlocked`=0 → IDLE.
- FAULT: all control and door outputs are 0. The only exit is reset.
- Doors are never open while `pressurizeCtrl` or `evacuateCtrl` is high. At most one door output is high in any cycle.
- Reset mid-operation (any state): outputs go to 0 asynchronously, the next state is IDLE, `cnt` is 0, and `fault` is cleared.

## Timing
- A request is sampled at edge N. The matching control or door output is high after edge N and stays high through the cycle following that edge.
- A door opened with no obstruction is high for exactly DOOR_CYCLES cycles, then IDLE is entered.
- A blockage extends the open time: the door closes DOOR_CYCLES cycles after the last cycle in which `doorBlocked`=1.
- The chamber control level is held from entry of EVAC/PRESS until the edge at which the status is seen. The door opens in the following cycle.
- Fault timing: if the chamber never responds, `fault` rises exactly TIMEOUT cycles after EVAC/PRESS was entered.
- Status is sampled synchronously. Status arriving on the last allowed cycle (`cnt`==TIMEOUT-1) is accepted; no fault is raised.

## Test plan
- Reset with defaults, then release `rst`, with `evacuated`=1 → all outputs 0. Pulse `outerReq` → `outerDoorOpen` high for exactly 8 cycles, then `busy`=0.
- From evacuated, pulse `innerReq`, with a chamber model reporting `pressurized` 7 cycles later → `pressurizeCtrl` high for 7 cycles. Then `innerDoorOpen` high for 8 cycles. No cycle has a door and a control high together.
- In OPEN_INNER, assert `doorBlocked` for cycles 5–10 of the dwell → the door closes 8 cycles after `doorBlocked` falls. Pulse `outerReq` during the dwell → ignored, no EVAC afterwards.
- From pressurized, with a chamber model that never reports `evacuated`, pulse `outerReq` → `evacuateCtrl` high for 16 cycles, then `fault`=1 and `busy`=1, held. Further requests have no effect.
- Set `evacuated`=1 and pulse `outerReq` and `innerReq` in the same cycle → OPEN_OUTER only.
- During PRESS, assert `rst` low mid-cycle → `pressurizeCtrl` falls immediately. After release the block is in IDLE with all outputs 0.
- Status boundary: `pressurized` arriving exactly on the 16th PRESS cycle → OPEN_INNER with no fault. Arriving on the 17th → FAULT.
